gemm_tile_scheduler: RTL and testbench
======================================

// Module: gemm_tile_scheduler
// PURPOSE
//  Sequencing controller for the tiled GeMM datapath. On start it walks all (m,n,k) tiles of
//  C[Msz x Nsz] = A[Msz x Ksz] * B[Ksz x Nsz] and drives the SRAM A/B read addresses and C write address/enable.
//  It also drives the MxNxK MAC-array control strobes. It sits in gemm_accelerator_top between start/size inputs and the array + SRAMs.
// PARAMETERS
//  M            4  tile rows (A/C); power of two
//  N            4  tile cols (B/C); power of two
//  K            4  tile depth; power of two
//  AddrWidth    6  SRAM word-address width
//  SizeAddrWidth 8 width of size inputs
//  MemLatency   1  cycles from address out to rdata valid
//  PeLatency    1  cycles from last mac_valid_o of a tile to C tile valid at sram_c_wdata
// PORTS
//  clk_i         in   1              clock
//  rst_i         in   1              synchronous reset, active-high
//  start_i       in   1              start pulse; sampled only in IDLE
//  M_size_i      in   SizeAddrWidth  rows of A/C; multiple of M
//  K_size_i      in   SizeAddrWidth  cols of A / rows of B; multiple of K
//  N_size_i      in   SizeAddrWidth  cols of B/C; multiple of N
//  sram_a_addr_o out  AddrWidth      A tile word address = mt*Kt+kt
//  sram_b_addr_o out  AddrWidth      B tile word address = kt*Nt+nt
//  sram_c_addr_o out  AddrWidth      C tile word address = mt*Nt+nt
//  sram_c_we_o   out  1              C write strobe, one cycle per output tile
//  mac_valid_o   out  1              A/B rdata valid at array this cycle
//  acc_clr_o     out  1              with mac_valid_o: kt==0, accumulator loads instead of adds
//  busy_o        out  1              high from ISSUE to DONE inclusive
//  done_o        out  1              one-cycle completion pulse
//  cfg_err_o     out  1              valid with done_o; sizes rejected, no SRAM access made
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; counters/delay lines cleared. Reset mid-run aborts, no done_o.
//  Tile counts latched on start: Mt=M_size_i/M, Kt=K_size_i/K, Nt=N_size_i/N (shifts).
//  Sizes after start are ignored.
//  Config error: any size 0, not a tile multiple, Mt*Kt, Kt*Nt or Mt*Nt > 2**AddrWidth.
//  On error: IDLE->DONE directly, done_o=cfg_err_o=1 for one cycle, no we/valid.
//  FSM: IDLE -start&ok-> ISSUE -last (mt,nt,kt) issued-> DRAIN -delay lines empty-> DONE -> IDLE.
//  ISSUE: one address pair per cycle, no bubbles; loop order mt outer, nt, kt inner.
//  Addresses from running bases (add Kt/Nt), no multipliers; results truncated to AddrWidth.
//  Tag {first,last,c_addr} per issue. Delay MemLatency -> mac_valid_o/acc_clr_o.
//  last delayed a further PeLatency -> sram_c_we_o with its c_addr.
//  Kt==1: acc_clr_o and last on the same beat. Back-to-back output tiles need no gap.
//  Timing, start at cycle 0: issue cycles 1..T, T=Mt*Nt*Kt. mac_valid_o on cycles 1+MemLatency..T+MemLatency.
//  Last we at T+MemLatency+PeLatency; done_o the following cycle. Exactly Mt*Nt we pulses.
//  start_i while busy_o: ignored. sram_*_addr_o hold last value outside ISSUE. sram_c_addr_o=0 when we=0.
// STRUCTURE
//  gemm_pkg: sched_state_e {IDLE,ISSUE,DRAIN,DONE}; tile-count/log2 helper constants.
//  Sub-module gemm_pipe_delay #(Width,Depth): reset-clearable shift register for tags; Depth 0 = wire.
// TESTING
//  8x8x8 (M=N=K=4, lat 1/1): A addr 0,1,0,1,2,3,2,3; B 0,2,1,3,0,2,1,3; acc_clr on 1st/3rd/5th/7th valid.
//   C we cycles 4,6,8,10 at addr 0,1,2,3; done cycle 11.
//  32x32x32: 512 issue cycles, 64 we pulses at addr 0..63 in order, done cycle 515; vs golden model.
//  4x4x4 (Kt=1): single beat, acc_clr_o and valid cycle 2, we addr 0 cycle 3, done cycle 4.
//  M_size_i=6 -> done_o=cfg_err_o=1 cycle 1, zero we/valid. Sizes 64x64x4 (Mt*Nt=256>64) -> cfg_err_o.
//  rst_i at cycle 5 of 8x8x8 run: next cycle all outputs 0, IDLE. New start runs cleanly.
//  start_i re-pulsed during ISSUE: ignored, addr sequence and we count unchanged.

Source files
------------

// File: rtl/gemm_pkg.sv
// Shared types and helpers for the GeMM tile scheduler: FSM state encoding,
// tag layout width and the tile-count range check used on start.
package gemm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } sched_state_e;

    // Tag carries {valid, first, last} ahead of the C tile address.
    localparam int TagFlagBits = 3;

    // True when the tile-count product a*b still fits in an address space of 'limit' words.
    function automatic logic tilesFit(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] limit);
        return ({32'b0, a} * {32'b0, b}) <= {32'b0, limit};
    endfunction

endpackage

// File: rtl/gemm_pipe_delay.sv
// Reset-clearable shift register used to align issue tags with SRAM and PE latency.
// A depth of zero collapses to a plain wire.
module gemm_pipe_delay #(
    parameter int Width = 1,
    parameter int Depth = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] data_o
);

    if (Depth == 0) begin : g_wire
        assign data_o = data_i;
    end else begin : g_shift
        logic [Width-1:0] stage_q [Depth];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int i = 0; i < Depth; i++) stage_q[i] <= '0;
            end else begin
                stage_q[0] <= data_i;
                for (int i = 1; i < Depth; i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign data_o = stage_q[Depth-1];
    end

endmodule

// File: rtl/gemm_tile_scheduler.sv
// Walks all (mt,nt,kt) tiles of a tiled GeMM, issuing A/B SRAM reads one per cycle
// and emitting MAC-array strobes and C write strobes aligned to memory/PE latency.
module gemm_tile_scheduler
    import gemm_pkg::*;
#(
    parameter int M             = 4,
    parameter int N             = 4,
    parameter int K             = 4,
    parameter int AddrWidth     = 6,
    parameter int SizeAddrWidth = 8,
    parameter int MemLatency    = 1,
    parameter int PeLatency     = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [SizeAddrWidth-1:0] M_size_i,
    input  logic [SizeAddrWidth-1:0] K_size_i,
    input  logic [SizeAddrWidth-1:0] N_size_i,
    output logic [AddrWidth-1:0]     sram_a_addr_o,
    output logic [AddrWidth-1:0]     sram_b_addr_o,
    output logic [AddrWidth-1:0]     sram_c_addr_o,
    output logic                     sram_c_we_o,
    output logic                     mac_valid_o,
    output logic                     acc_clr_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     cfg_err_o
);

    localparam int SW          = SizeAddrWidth;
    localparam int LogM        = $clog2(M);
    localparam int LogN        = $clog2(N);
    localparam int LogK        = $clog2(K);
    localparam int AddrSpace   = 1 << AddrWidth;
    localparam int DrainCycles = MemLatency + PeLatency;
    localparam int DrainLoad   = (DrainCycles > 0) ? DrainCycles - 1 : 0;
    localparam int DrainW      = 8;
    localparam int TagW        = TagFlagBits + AddrWidth;

    localparam logic [SW-1:0]        OneS = 1;
    localparam logic [AddrWidth-1:0] OneA = 1;
    localparam logic [DrainW-1:0]    OneD = 1;

    sched_state_e state_q, state_d;

    logic [SW-1:0]        mtNum_q, mtNum_d, ktNum_q, ktNum_d, ntNum_q, ntNum_d;
    logic [SW-1:0]        mt_q, mt_d, nt_q, nt_d, kt_q, kt_d;
    logic [AddrWidth-1:0] aRow_q, aRow_d, aAddr_q, aAddr_d, bAddr_q, bAddr_d, cAddr_q, cAddr_d;
    logic [DrainW-1:0]    drainCnt_q, drainCnt_d;
    logic                 cfgErr_q, cfgErr_d;

    logic [SW-1:0] mtIn, ktIn, ntIn;
    logic          cfgOk, startAccept;
    logic          lastKt, lastNt, lastMt, lastIssue;

    logic [TagW-1:0]        issueTag, macTag;
    logic [AddrWidth:0]     peIn, peOut;
    logic                   macValid, macFirst, macLast, weTag;
    logic [AddrWidth-1:0]   macAddr, weAddr;

    // Tile counts are shifts of the sizes; the products only gate acceptance.
    always_comb begin
        mtIn  = M_size_i >> LogM;
        ktIn  = K_size_i >> LogK;
        ntIn  = N_size_i >> LogN;
        cfgOk = (mtIn != '0) && (ktIn != '0) && (ntIn != '0)
             && ((M_size_i & SW'(M - 1)) == '0)
             && ((K_size_i & SW'(K - 1)) == '0)
             && ((N_size_i & SW'(N - 1)) == '0)
             && tilesFit(32'(mtIn), 32'(ktIn), 32'(AddrSpace))
             && tilesFit(32'(ktIn), 32'(ntIn), 32'(AddrSpace))
             && tilesFit(32'(mtIn), 32'(ntIn), 32'(AddrSpace));
    end

    assign startAccept = (state_q == IDLE) && start_i;
    assign lastKt      = (kt_q == ktNum_q - OneS);
    assign lastNt      = (nt_q == ntNum_q - OneS);
    assign lastMt      = (mt_q == mtNum_q - OneS);
    assign lastIssue   = lastKt && lastNt && lastMt;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = cfgOk ? ISSUE : DONE;
            ISSUE:   if (lastIssue) state_d = (DrainCycles == 0) ? DONE : DRAIN;
            DRAIN:   if (drainCnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o        = (state_q != IDLE);
        done_o        = (state_q == DONE);
        cfg_err_o     = (state_q == DONE) && cfgErr_q;
        mac_valid_o   = macValid;
        acc_clr_o     = macValid && macFirst;
        sram_c_we_o   = weTag;
        sram_c_addr_o = weTag ? weAddr : '0;
    end

    // Addresses advance from running bases; a rejected start leaves them untouched.
    always_comb begin
        mtNum_d    = mtNum_q;
        ktNum_d    = ktNum_q;
        ntNum_d    = ntNum_q;
        cfgErr_d   = cfgErr_q;
        mt_d       = mt_q;
        nt_d       = nt_q;
        kt_d       = kt_q;
        aRow_d     = aRow_q;
        aAddr_d    = aAddr_q;
        bAddr_d    = bAddr_q;
        cAddr_d    = cAddr_q;
        drainCnt_d = drainCnt_q;
        if (startAccept) begin
            mtNum_d  = mtIn;
            ktNum_d  = ktIn;
            ntNum_d  = ntIn;
            cfgErr_d = !cfgOk;
            if (cfgOk) begin
                mt_d    = '0;
                nt_d    = '0;
                kt_d    = '0;
                aRow_d  = '0;
                aAddr_d = '0;
                bAddr_d = '0;
                cAddr_d = '0;
            end
        end else if (state_q == ISSUE) begin
            if (lastIssue) begin
                drainCnt_d = DrainW'(DrainLoad);
            end else if (!lastKt) begin
                kt_d    = kt_q + OneS;
                aAddr_d = aAddr_q + OneA;
                bAddr_d = bAddr_q + AddrWidth'(ntNum_q);
            end else if (!lastNt) begin
                kt_d    = '0;
                nt_d    = nt_q + OneS;
                aAddr_d = aRow_q;
                bAddr_d = AddrWidth'(nt_q + OneS);
                cAddr_d = cAddr_q + OneA;
            end else begin
                kt_d    = '0;
                nt_d    = '0;
                mt_d    = mt_q + OneS;
                aRow_d  = aRow_q + AddrWidth'(ktNum_q);
                aAddr_d = aRow_q + AddrWidth'(ktNum_q);
                bAddr_d = '0;
                cAddr_d = cAddr_q + OneA;
            end
        end else if (state_q == DRAIN) begin
            drainCnt_d = drainCnt_q - OneD;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtNum_q    <= '0;
            ktNum_q    <= '0;
            ntNum_q    <= '0;
            cfgErr_q   <= 1'b0;
            mt_q       <= '0;
            nt_q       <= '0;
            kt_q       <= '0;
            aRow_q     <= '0;
            aAddr_q    <= '0;
            bAddr_q    <= '0;
            cAddr_q    <= '0;
            drainCnt_q <= '0;
        end else begin
            mtNum_q    <= mtNum_d;
            ktNum_q    <= ktNum_d;
            ntNum_q    <= ntNum_d;
            cfgErr_q   <= cfgErr_d;
            mt_q       <= mt_d;
            nt_q       <= nt_d;
            kt_q       <= kt_d;
            aRow_q     <= aRow_d;
            aAddr_q    <= aAddr_d;
            bAddr_q    <= bAddr_d;
            cAddr_q    <= cAddr_d;
            drainCnt_q <= drainCnt_d;
        end
    end

    assign sram_a_addr_o = aAddr_q;
    assign sram_b_addr_o = bAddr_q;

    // Tags ride alongside the reads so strobes line up with rdata and PE output.
    assign issueTag = {state_q == ISSUE, kt_q == '0, lastKt, cAddr_q};

    gemm_pipe_delay #(.Width(TagW), .Depth(MemLatency)) u_mem_delay (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .data_i (issueTag),
        .data_o (macTag)
    );

    assign {macValid, macFirst, macLast, macAddr} = macTag;
    assign peIn = {macValid && macLast, macAddr};

    gemm_pipe_delay #(.Width(AddrWidth + 1), .Depth(PeLatency)) u_pe_delay (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .data_i (peIn),
        .data_o (peOut)
    );

    assign {weTag, weAddr} = peOut;

endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Self-checking bench for gemm_tile_scheduler: a cycle-indexed behavioural model
// of the tile walk is compared against every DUT output on each falling edge.
module tb_gemm_tile_scheduler;

    localparam int AW     = 6;
    localparam int SW     = 8;
    localparam int ML     = 1;
    localparam int PL     = 1;
    localparam int TILE   = 4;
    localparam int ASPACE = 64;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [SW-1:0] mSize, kSize, nSize;
    logic [AW-1:0] aAddr, bAddr, cAddr;
    logic          cWe, macValid, accClr, busy, done, cfgErr;

    always #5 clk_i = ~clk_i;

    gemm_tile_scheduler #(
        .M(TILE), .N(TILE), .K(TILE), .AddrWidth(AW), .SizeAddrWidth(SW),
        .MemLatency(ML), .PeLatency(PL)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .M_size_i      (mSize),
        .K_size_i      (kSize),
        .N_size_i      (nSize),
        .sram_a_addr_o (aAddr),
        .sram_b_addr_o (bAddr),
        .sram_c_addr_o (cAddr),
        .sram_c_we_o   (cWe),
        .mac_valid_o   (macValid),
        .acc_clr_o     (accClr),
        .busy_o        (busy),
        .done_o        (done),
        .cfg_err_o     (cfgErr)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit checkEn = 1'b0;

    bit haveRun = 1'b0;
    bit mErr    = 1'b0;
    int mStart  = 0;
    int mMt = 1, mKt = 1, mNt = 1;
    int holdA = 0, holdB = 0;

    int aLog[$], bLog[$], validLog[$], clrLog[$], weCycLog[$], weAddrLog[$];
    int doneRel = -1;
    int weCnt   = 0;
    int expQ[$];

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic checkQueue(input string name, input int got[$], input int exp[$]);
        checkOutput({name, " length"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            checkOutput(name, got[i], exp[i]);
    endtask

    function automatic bit sizesBad(input int ms, input int ks, input int ns);
        int mt, kt, nt;
        mt = ms / TILE;
        kt = ks / TILE;
        nt = ns / TILE;
        if (ms == 0 || ks == 0 || ns == 0) return 1'b1;
        if ((ms % TILE) != 0 || (ks % TILE) != 0 || (ns % TILE) != 0) return 1'b1;
        return (mt * kt > ASPACE) || (kt * nt > ASPACE) || (mt * nt > ASPACE);
    endfunction

    function automatic int lastRel(input bit err, input int mt, input int nt, input int kt);
        return err ? 1 : mt * nt * kt + ML + PL + 1;
    endfunction

    // Model: record each accepted start; the run is then a pure function of (cycle - start).
    always @(posedge clk_i) begin : model
        int mt, kt, nt;
        bit bad;
        if (rst_i) begin
            haveRun <= 1'b0;
            holdA   <= 0;
            holdB   <= 0;
        end else if (start_i && (!haveRun || (cyc - mStart) > lastRel(mErr, mMt, mNt, mKt))) begin
            bad = sizesBad(int'(mSize), int'(kSize), int'(nSize));
            mt  = int'(mSize) / TILE;
            kt  = int'(kSize) / TILE;
            nt  = int'(nSize) / TILE;
            haveRun <= 1'b1;
            mStart  <= cyc;
            mErr    <= bad;
            mMt     <= mt;
            mKt     <= kt;
            mNt     <= nt;
            if (!bad) begin
                holdA <= ((mt - 1) * kt + kt - 1) % ASPACE;
                holdB <= ((kt - 1) * nt + nt - 1) % ASPACE;
            end
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk_i) begin : compare
        int r, t, i, j, eA, eB, eC;
        bit eV, eClr, eWe, eDone, eErr, eBusy, skipBusy;
        if (checkEn) begin
            r = cyc - mStart;
            eA = holdA; eB = holdB; eC = 0;
            eV = 0; eClr = 0; eWe = 0; eDone = 0; eErr = 0; eBusy = 0; skipBusy = 0;
            if (haveRun) begin
                if (r == 1) begin
                    aLog.delete(); bLog.delete(); validLog.delete(); clrLog.delete();
                    weCycLog.delete(); weAddrLog.delete();
                    weCnt = 0;
                    doneRel = -1;
                end
                if (mErr) begin
                    if (r == 1) begin
                        eDone = 1; eErr = 1; skipBusy = 1;
                    end
                end else begin
                    t = mMt * mNt * mKt;
                    if (r >= 1 && r <= t) begin
                        i  = r - 1;
                        eA = ((i / (mKt * mNt)) * mKt + i % mKt) % ASPACE;
                        eB = ((i % mKt) * mNt + (i / mKt) % mNt) % ASPACE;
                        aLog.push_back(int'(aAddr));
                        bLog.push_back(int'(bAddr));
                    end
                    j = r - 1 - ML;
                    if (j >= 0 && j < t) begin
                        eV   = 1;
                        eClr = (j % mKt == 0);
                    end
                    j = r - 1 - ML - PL;
                    if (j >= 0 && j < t && (j % mKt) == mKt - 1) begin
                        eWe = 1;
                        eC  = (j / mKt) % ASPACE;
                    end
                    eBusy = (r >= 1) && (r <= t + ML + PL + 1);
                    eDone = (r == t + ML + PL + 1);
                end
                if (macValid) begin
                    validLog.push_back(r);
                    clrLog.push_back(int'(accClr));
                end
                if (cWe) begin
                    weCycLog.push_back(r);
                    weAddrLog.push_back(int'(cAddr));
                    weCnt++;
                end
                if (done) doneRel = r;
            end
            checkOutput("sram_a_addr", int'(aAddr), eA);
            checkOutput("sram_b_addr", int'(bAddr), eB);
            checkOutput("sram_c_addr", int'(cAddr), eC);
            checkOutput("sram_c_we", int'(cWe), int'(eWe));
            checkOutput("mac_valid", int'(macValid), int'(eV));
            checkOutput("acc_clr", int'(accClr), int'(eClr));
            checkOutput("done", int'(done), int'(eDone));
            checkOutput("cfg_err", int'(cfgErr), int'(eErr));
            if (!skipBusy) checkOutput("busy", int'(busy), int'(eBusy));
        end
    end

    // One start pulse, optional ignored re-pulse, sizes scrambled after start, bounded wait for done.
    task automatic applyStimulus(input int ms, input int ks, input int ns, input bit repulse);
        bit seen = 1'b0;
        bit bad;
        bad = sizesBad(ms, ks, ns);
        @(posedge clk_i); #1;
        mSize = SW'(ms); kSize = SW'(ks); nSize = SW'(ns);
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        mSize = SW'($urandom); kSize = SW'($urandom); nSize = SW'($urandom);
        if (repulse) begin
            @(posedge clk_i); #1 start_i = 1'b1;
            @(posedge clk_i); #1 start_i = 1'b0;
        end
        for (int c = 0; c < 3000 && !seen; c++) begin
            @(negedge clk_i);
            if (done) seen = 1'b1;
        end
        checkOutput("done reached", int'(seen), 1);
        @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("done cycle", doneRel, lastRel(bad, ms / TILE, ns / TILE, ks / TILE));
        checkOutput("we count", weCnt, bad ? 0 : (ms / TILE) * (ns / TILE));
    endtask

    task automatic check8x8x8();
        expQ = '{0, 1, 0, 1, 2, 3, 2, 3};  checkQueue("8x8x8 a seq", aLog, expQ);
        expQ = '{0, 2, 1, 3, 0, 2, 1, 3};  checkQueue("8x8x8 b seq", bLog, expQ);
        expQ = '{2, 3, 4, 5, 6, 7, 8, 9};  checkQueue("8x8x8 valid cycles", validLog, expQ);
        expQ = '{1, 0, 1, 0, 1, 0, 1, 0};  checkQueue("8x8x8 acc_clr", clrLog, expQ);
        expQ = '{4, 6, 8, 10};             checkQueue("8x8x8 we cycles", weCycLog, expQ);
        expQ = '{0, 1, 2, 3};              checkQueue("8x8x8 we addr", weAddrLog, expQ);
        checkOutput("8x8x8 done at 11", doneRel, 11);
    endtask

    initial begin
        int doneCount;
        rst_i = 1'b1;
        start_i = 1'b0;
        mSize = '0; kSize = '0; nSize = '0;
        repeat (2) @(posedge clk_i);
        #1 checkEn = 1'b1;
        @(negedge clk_i);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset mac_valid", int'(macValid), 0);
        checkOutput("reset a_addr", int'(aAddr), 0);
        @(posedge clk_i); #1 rst_i = 1'b0;

        applyStimulus(8, 8, 8, 1'b0);
        check8x8x8();

        applyStimulus(4, 4, 4, 1'b0);
        expQ = '{2}; checkQueue("4x4x4 valid cycles", validLog, expQ);
        expQ = '{1}; checkQueue("4x4x4 acc_clr", clrLog, expQ);
        expQ = '{3}; checkQueue("4x4x4 we cycles", weCycLog, expQ);
        expQ = '{0}; checkQueue("4x4x4 we addr", weAddrLog, expQ);
        checkOutput("4x4x4 done at 4", doneRel, 4);

        applyStimulus(32, 32, 32, 1'b0);
        checkOutput("32^3 done at 515", doneRel, 515);
        checkOutput("32^3 we pulses", weAddrLog.size(), 64);
        for (int i = 0; i < 64 && i < weAddrLog.size(); i++)
            checkOutput("32^3 we addr order", weAddrLog[i], i);

        applyStimulus(6, 8, 8, 1'b0);
        checkOutput("M=6 done at 1", doneRel, 1);
        checkOutput("M=6 no valid", validLog.size(), 0);

        applyStimulus(64, 4, 64, 1'b0);
        checkOutput("64x64x4 done at 1", doneRel, 1);
        checkOutput("64x64x4 no we", weCnt, 0);

        applyStimulus(8, 8, 8, 1'b1);
        check8x8x8();

        // Reset during cycle 5 of an 8x8x8 run.
        @(posedge clk_i); #1;
        mSize = 8; kSize = 8; nSize = 8; start_i = 1'b1;
        @(posedge clk_i); #1 start_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(posedge clk_i); #1 rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("post-reset busy", int'(busy), 0);
        checkOutput("post-reset valid", int'(macValid), 0);
        checkOutput("post-reset a_addr", int'(aAddr), 0);
        checkOutput("post-reset b_addr", int'(bAddr), 0);
        doneCount = 0;
        repeat (15) begin
            @(negedge clk_i);
            if (done) doneCount++;
        end
        checkOutput("aborted run done pulses", doneCount, 0);
        applyStimulus(8, 8, 8, 1'b0);
        check8x8x8();

        for (int n = 0; n < 12; n++) begin
            int ms, ks, ns;
            bit rp;
            ms = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : 4 * int'($urandom_range(1, 6));
            ks = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : 4 * int'($urandom_range(1, 6));
            ns = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : 4 * int'($urandom_range(1, 6));
            rp = !sizesBad(ms, ks, ns) && ((ms / TILE) * (ks / TILE) * (ns / TILE) >= 4)
                 && ($urandom_range(0, 1) == 1);
            applyStimulus(ms, ks, ns, rp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
